// File: rtl/vga_tile_framebuffer_if.sv
// vga_tile_framebuffer_if: tile writer port with bank-swap handshake
interface vga_tile_framebuffer_if #(parameter int ADDR_W = 11);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              swap_req;
  logic              swap_done;
  logic              front_bank;
  modport master(output wr_valid, wr_addr, wr_data, swap_req, input wr_ready, swap_done, front_bank);
  modport slave(input wr_valid, wr_addr, wr_data, swap_req, output wr_ready, swap_done, front_bank);
endinterface

// File: rtl/vga_tile_framebuffer.sv
// vga_tile_framebuffer: double-buffered 12-bit tile framebuffer feeding RGB444 VGA pins
module vga_tile_framebuffer #(
  parameter int H_START   = 144,
  parameter int V_START   = 35,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int TILE_LOG2 = 4,
  parameter int ADDR_W    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vblank_in,
  vga_tile_framebuffer_if.slave wr,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  localparam int COLS  = H_ACTIVE >> TILE_LOG2;
  localparam int ROWS  = V_ACTIVE >> TILE_LOG2;
  localparam int CELLS = COLS * ROWS;
  typedef enum logic {WRITE, PENDING} state_t;
  state_t            state;
  logic [11:0]       mem0 [CELLS];
  logic [11:0]       mem1 [CELLS];
  logic [10:0]       h_off;
  logic [10:0]       v_off;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] s1_addr;
  logic              active;
  logic              s1_active;
  logic              s1_hs;
  logic              s1_vs;
  logic              vb_q;
  logic              vb_rise;
  logic              wr_fire;
  assign h_off   = h_count - 11'(H_START);
  assign v_off   = v_count - 11'(V_START);
  assign active  = h_count >= 11'(H_START) && h_count < 11'(H_START + H_ACTIVE) &&
                   v_count >= 11'(V_START) && v_count < 11'(V_START + V_ACTIVE);
  assign addr    = active ? ADDR_W'(32'(v_off >> TILE_LOG2) * COLS + 32'(h_off >> TILE_LOG2)) : '0;
  assign vb_rise = pix_en & vblank_in & ~vb_q;
  assign wr_fire = wr.wr_valid & wr.wr_ready & (wr.wr_addr < ADDR_W'(CELLS));
  // Writer always targets the bank not on screen; tiles past the grid are dropped
  always_ff @(posedge clk) begin
    if (wr_fire && wr.front_bank) mem0[wr.wr_addr] <= wr.wr_data;
    if (wr_fire && !wr.front_bank) mem1[wr.wr_addr] <= wr.wr_data;
  end
  // Two-stage pixel pipeline: S1 tile address and syncs, S2 front-bank read masked outside the window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_addr   <= '0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      {vga_r, vga_g, vga_b} <= 12'h000;
    end else if (pix_en) begin
      s1_addr   <= addr;
      s1_active <= active;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      hsync     <= s1_hs;
      vsync     <= s1_vs;
      {vga_r, vga_g, vga_b} <= !s1_active ? 12'h000 : wr.front_bank ? mem1[s1_addr] : mem0[s1_addr];
    end
  end
  // Swap control: a completed back bank is held off the writer until the next vblank rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WRITE;
      wr.wr_ready   <= 1'b1;
      wr.front_bank <= 1'b0;
      wr.swap_done  <= 1'b0;
      vb_q          <= 1'b0;
    end else begin
      wr.swap_done <= 1'b0;
      if (pix_en) vb_q <= vblank_in;
      if (state == WRITE && wr.swap_req) begin
        state       <= PENDING;
        wr.wr_ready <= 1'b0;
      end else if (state == PENDING && vb_rise) begin
        state         <= WRITE;
        wr.wr_ready   <= 1'b1;
        wr.front_bank <= ~wr.front_bank;
        wr.swap_done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// tb_vga_tile_framebuffer: scoreboard bench for tile framebuffer pixels, syncs and bank swaps
module tb_vga_tile_framebuffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [10:0] h_count = '0;
  logic [10:0] v_count = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        vblank_in = 1'b0;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic [11:0] m0 [1200];
  logic [11:0] m1 [1200];
  logic [13:0] q [$];
  logic [13:0] last = '0;
  bit          mfront = 1'b0;
  bit          mpend = 1'b0;
  bit          mvb = 1'b0;
  int          checks = 0;
  int          errors = 0;
  vga_tile_framebuffer_if bus();
  vga_tile_framebuffer dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .vblank_in(vblank_in), .wr(bus),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] exp_rgb(int h, int v);
    int a;
    if (h < 144 || h >= 784 || v < 35 || v >= 515) return 12'h000;
    a = ((v - 35) / 16) * 40 + (h - 144) / 16;
    return mfront ? m1[a] : m0[a];
  endfunction
  task automatic step(bit pe, int h, int v, bit hs, bit vs, bit vb, bit wv, int wa, logic [11:0] wd, bit sr);
    bit rise;
    bit swp;
    pix_en = pe;
    h_count = 11'(h);
    v_count = 11'(v);
    hsync_in = hs;
    vsync_in = vs;
    vblank_in = vb;
    bus.wr_valid = wv;
    bus.wr_addr = 11'(wa);
    bus.wr_data = wd;
    bus.swap_req = sr;
    @(posedge clk);
    #1;
    rise = pe && vb && !mvb;
    if (pe) mvb = vb;
    if (wv && !mpend && wa < 1200) begin
      if (mfront) m0[wa] = wd;
      else m1[wa] = wd;
    end
    swp = 1'b0;
    if (!mpend) mpend = sr;
    else if (rise) begin
      mfront = !mfront;
      mpend = 1'b0;
      swp = 1'b1;
    end
    chk("swap_done", 32'(bus.swap_done), 32'(swp));
    chk("front_bank", 32'(bus.front_bank), 32'(mfront));
    chk("wr_ready", 32'(bus.wr_ready), 32'(!mpend));
    if (pe) begin
      q.push_back({hs, vs, exp_rgb(h, v)});
      if (q.size() == 2) last = q.pop_front();
    end
    chk(pe ? "pixel" : "pixel_hold", 32'({hsync, vsync, vga_r, vga_g, vga_b}), 32'(last));
    pix_en = 1'b0;
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
  endtask
  task automatic pix(int h, int v, bit hs, bit vs, bit vb);
    step(1'b1, h, v, hs, vs, vb, 1'b0, 0, 12'h000, 1'b0);
    step(1'b0, h, v, hs, vs, vb, 1'b0, 0, 12'h000, 1'b0);
  endtask
  task automatic wr(int a, logic [11:0] d, bit sr);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, a, d, sr);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.swap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'({hsync, vsync, vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_front", 32'(bus.front_bank), 32'h0);
    chk("rst_ready", 32'(bus.wr_ready), 32'h1);
    chk("rst_done", 32'(bus.swap_done), 32'h0);
    reset = 1'b0;
    pix(143, 34, 1, 0, 0);
    pix(784, 34, 0, 1, 0);
    pix(143, 515, 1, 1, 0);
    pix(784, 515, 0, 0, 0);
    pix(100, 600, 1, 0, 0);
    wr(1200, 12'h123, 1'b0);
    wr(2047, 12'h456, 1'b0);
    for (int i = 0; i < 1200; i++) wr(i, 12'hF00, i == 1199);
    for (int i = 0; i < 10; i++) wr(i * 100, 12'h00F, 1'b0);
    pix(100, 520, 0, 1, 1);
    pix(144, 35, 1, 0, 0);
    pix(783, 514, 0, 1, 0);
    pix(400, 300, 1, 1, 0);
    pix(784, 300, 0, 0, 0);
    pix(143, 300, 1, 0, 0);
    pix(400, 34, 0, 1, 0);
    pix(400, 515, 0, 0, 0);
    pix(244, 35, 0, 0, 0);
    for (int i = 0; i < 1200; i++) wr(i, i == 83 ? 12'h0A5 : 12'(i * 37), 1'b0);
    step(1'b1, 0, 520, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000, 1'b1);
    pix(0, 521, 0, 0, 1);
    pix(144, 35, 0, 0, 0);
    pix(0, 520, 0, 0, 1);
    pix(192, 67, 0, 0, 0);
    pix(207, 82, 1, 0, 0);
    pix(200, 75, 0, 0, 0);
    pix(191, 67, 0, 1, 0);
    pix(208, 67, 0, 0, 0);
    pix(192, 66, 1, 1, 0);
    pix(192, 83, 0, 0, 0);
    pix(783, 514, 0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    pix(0, 520, 0, 0, 1);
    pix(300, 200, 0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    pix(300, 100, 1, 1, 0);
    pix(300, 100, 1, 1, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out", 32'({hsync, vsync, vga_r, vga_g, vga_b}), 32'h0);
    chk("arst_front", 32'(bus.front_bank), 32'h0);
    chk("arst_ready", 32'(bus.wr_ready), 32'h1);
    mfront = 1'b0;
    mpend = 1'b0;
    mvb = 1'b0;
    q.delete();
    last = '0;
    #2;
    reset = 1'b0;
    pix(143, 34, 1, 0, 0);
    pix(784, 515, 0, 1, 0);
    pix(100, 520, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
